// File: rtl/mor1kx_icache_pkg.sv
// Shared types and Wishbone B3 constants for the instruction-cache refill path.
package mor1kx_icache_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } refill_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;

  // Burst type matching the line size: 16 B lines wrap on 4 words, 32 B on 8.
  function automatic logic [1:0] bte_for_block(input int block_width);
    return (block_width == 4) ? BTE_WRAP4 : BTE_WRAP8;
  endfunction

endpackage

// File: rtl/mor1kx_wrap_adr_gen.sv
// Wrapping burst address generator: holds the current word address and the
// remaining-beat count for one cache line. The word offset [BW-1:2] wraps
// modulo the line size while the tag/index bits above it stay fixed.
module mor1kx_wrap_adr_gen #(
  parameter int AW = 32,
  parameter int BW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] base_adr,
  output logic [AW-1:0] adr_o,
  output logic          last_o
);

  localparam int OW = BW - 2;

  logic [AW-1:0] adr_q, adr_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] off_inc;

  // Load starts a new line (count = words-1); each accepted beat steps the offset.
  always_comb begin
    off_inc = adr_q[BW-1:2] + OW'(1);
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    if (load) begin
      adr_d = {base_adr[AW-1:2], 2'b00};
      cnt_d = '1;
    end else if (advance) begin
      adr_d = {adr_q[AW-1:BW], off_inc, 2'b00};
      cnt_d = cnt_q - OW'(1);
    end
  end

  // Address and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q <= '0;
      cnt_q <= '0;
    end else begin
      adr_q <= adr_d;
      cnt_q <= cnt_d;
    end
  end

  assign adr_o  = adr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mor1kx_icache_refill_ctrl.sv
// Instruction-cache line refill master: fetches one cache line as a Wishbone
// B3 wrapping burst and streams each acked word straight into the cache
// write port. Optional build macro MOR1KX_ICACHE_CRITICAL_WORD_FIRST_EN starts
// the burst at the missed word instead of the line-aligned address.
// OPTION_ICACHE_BLOCK_WIDTH must be 4 or 5.
module mor1kx_icache_refill_ctrl
  import mor1kx_icache_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  input  logic                            refill_done_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            err_o,
  output logic                            busy_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic [2:0]                      wbm_cti_o,
  output logic [1:0]                      wbm_bte_o,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i
);

  localparam int AW = OPTION_OPERAND_WIDTH;
  localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;

  refill_state_t state_q, state_d;
  logic          cyc_q, cyc_d;
  logic [1:0]    bte_q, bte_d;
  logic          err_q, err_d;

  logic          in_burst;
  logic          ack_ok;
  logic          last_beat;
  logic          last_ack;
  logic          load;
  logic [AW-1:0] start_adr;

  assign in_burst = (state_q == BURST);
  // Error wins over a simultaneous ack: that beat is neither written nor counted.
  assign ack_ok   = in_burst & wbm_ack_i & ~wbm_err_i;
  assign last_ack = ack_ok & last_beat;
  assign load     = ~in_burst & refill_req_i;

`ifdef MOR1KX_ICACHE_CRITICAL_WORD_FIRST_EN
  assign start_adr = {refill_adr_i[AW-1:2], 2'b00};
`else
  assign start_adr = {refill_adr_i[AW-1:BW], {BW{1'b0}}};
`endif

  mor1kx_wrap_adr_gen #(
    .AW(AW),
    .BW(BW)
  ) u_adr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (ack_ok),
    .base_adr (start_adr),
    .adr_o    (wbm_adr_o),
    .last_o   (last_beat)
  );

  // Next-state and registered bus controls for the IDLE/BURST machine.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bte_d   = bte_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (refill_req_i) begin
          state_d = BURST;
          cyc_d   = 1'b1;
          bte_d   = bte_for_block(BW);
        end
      end
      BURST: begin
        if (wbm_err_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cyc_d   = 1'b0;
          bte_d   = BTE_LINEAR;
        end else if (last_ack) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          bte_d   = BTE_LINEAR;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        bte_d   = BTE_LINEAR;
      end
    endcase
  end

  // FSM state and registered outputs; reset drops the cycle immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      bte_q   <= BTE_LINEAR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bte_q   <= bte_d;
      err_q   <= err_d;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  // End-of-burst is flagged on the beat where the remaining count reaches zero.
  assign wbm_cti_o = in_burst ? (last_beat ? CTI_EOB : CTI_INC) : CTI_CLASSIC;
  assign wbm_bte_o = bte_q;

  assign we_o    = ack_ok;
  assign wradr_o = wbm_adr_o;
  assign wrdat_o = wbm_dat_i;
  assign err_o   = err_q;
  assign busy_o  = in_burst;

`ifndef SYNTHESIS
  // The cache must see its line complete exactly on the final beat.
  always_ff @(posedge clk) begin
    if (!rst && last_ack) begin
      assert (refill_done_i);
    end
  end
`endif

endmodule

// File: tb/tb_mor1kx_icache_refill_ctrl.sv
// Directed bench for the icache refill controller: a 32 B-line instance and
// a 16 B-line instance, each with its own bus/cache stimulus.
module tb_mor1kx_icache_refill_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 32 B line instance
  logic        req_a, done_a, ack_a, berr_a;
  logic [31:0] radr_a, dat_a;
  logic [31:0] wradr_a, wrdat_a, adr_a;
  logic        we_a, erro_a, busy_a, cyc_a, stb_a;
  logic [2:0]  cti_a;
  logic [1:0]  bte_a;

  // 16 B line instance
  logic        req_b, done_b, ack_b, berr_b;
  logic [31:0] radr_b, dat_b;
  logic [31:0] wradr_b, wrdat_b, adr_b;
  logic        we_b, erro_b, busy_b, cyc_b, stb_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [31:0] exp32 [0:7];
  logic [31:0] exp16 [0:3];
  int          restart_off;

  mor1kx_icache_refill_ctrl #(
    .OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)
  ) u_dut32 (
    .clk(clk), .rst(rst),
    .refill_req_i(req_a), .refill_adr_i(radr_a), .refill_done_i(done_a),
    .wradr_o(wradr_a), .wrdat_o(wrdat_a), .we_o(we_a), .err_o(erro_a), .busy_o(busy_a),
    .wbm_adr_o(adr_a), .wbm_cyc_o(cyc_a), .wbm_stb_o(stb_a), .wbm_cti_o(cti_a),
    .wbm_bte_o(bte_a), .wbm_ack_i(ack_a), .wbm_err_i(berr_a), .wbm_dat_i(dat_a)
  );

  mor1kx_icache_refill_ctrl #(
    .OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)
  ) u_dut16 (
    .clk(clk), .rst(rst),
    .refill_req_i(req_b), .refill_adr_i(radr_b), .refill_done_i(done_b),
    .wradr_o(wradr_b), .wrdat_o(wrdat_b), .we_o(we_b), .err_o(erro_b), .busy_o(busy_b),
    .wbm_adr_o(adr_b), .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_cti_o(cti_b),
    .wbm_bte_o(bte_b), .wbm_ack_i(ack_b), .wbm_err_i(berr_b), .wbm_dat_i(dat_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
`ifdef MOR1KX_ICACHE_CRITICAL_WORD_FIRST_EN
    exp32 = '{32'h1000_0014, 32'h1000_0018, 32'h1000_001C, 32'h1000_0000,
              32'h1000_0004, 32'h1000_0008, 32'h1000_000C, 32'h1000_0010};
    exp16 = '{32'h2000_0008, 32'h2000_000C, 32'h2000_0000, 32'h2000_0004};
    restart_off = 1;
`else
    exp32 = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C,
              32'h1000_0010, 32'h1000_0014, 32'h1000_0018, 32'h1000_001C};
    exp16 = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008, 32'h2000_000C};
    restart_off = 0;
`endif
    rst = 1'b1;
    req_a = 0; done_a = 0; ack_a = 0; berr_a = 0; radr_a = '0; dat_a = '0;
    req_b = 0; done_b = 0; ack_b = 0; berr_b = 0; radr_b = '0; dat_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_cyc",  32'(cyc_a), 0);
    chk("rst_stb",  32'(stb_a), 0);
    chk("rst_cti",  32'(cti_a), 0);
    chk("rst_bte",  32'(bte_a), 0);
    chk("rst_adr",  adr_a, 0);
    chk("rst_err",  32'(erro_a), 0);
    chk("rst_we",   32'(we_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_busy16", 32'(busy_b), 0);
    rst = 1'b0;

    // Ack in IDLE is ignored
    ack_a = 1; dat_a = 32'hDEAD_BEEF;
    #1 chk("idle_ack_we", 32'(we_a), 0);
    @(negedge clk);
    chk("idle_ack_busy", 32'(busy_a), 0);
    chk("idle_ack_adr", adr_a, 0);
    ack_a = 0;

    // Full 32 B burst, zero wait states
    req_a = 1; radr_a = 32'h1000_0014;
    @(negedge clk);
    req_a = 0;
    chk("b1_busy", 32'(busy_a), 1);
    chk("b1_cyc",  32'(cyc_a), 1);
    chk("b1_stb",  32'(stb_a), 1);
    chk("b1_bte",  32'(bte_a), 2);
    for (int i = 0; i < 8; i++) begin
      ack_a = 1; dat_a = 32'hA000_0000 + 32'(i); done_a = (i == 7);
      #1;
      chk("b1_adr",   adr_a, exp32[i]);
      chk("b1_cti",   32'(cti_a), (i == 7) ? 7 : 2);
      chk("b1_we",    32'(we_a), 1);
      chk("b1_wradr", wradr_a, exp32[i]);
      chk("b1_wrdat", wrdat_a, 32'hA000_0000 + 32'(i));
      @(negedge clk);
    end
    ack_a = 0; done_a = 0;
    #1;
    chk("b1_end_busy", 32'(busy_a), 0);
    chk("b1_end_cyc",  32'(cyc_a), 0);
    chk("b1_end_cti",  32'(cti_a), 0);
    chk("b1_end_bte",  32'(bte_a), 0);
    chk("b1_end_we",   32'(we_a), 0);

    // Bus error on the 3rd beat with ack also high
    req_a = 1; radr_a = 32'h1000_0014;
    @(negedge clk);
    req_a = 0;
    for (int i = 0; i < 2; i++) begin
      ack_a = 1;
      #1 chk("e_we", 32'(we_a), 1);
      @(negedge clk);
    end
    ack_a = 1; berr_a = 1;
    #1;
    chk("e_we_on_err", 32'(we_a), 0);
    chk("e_erro_same", 32'(erro_a), 0);
    @(negedge clk);
    ack_a = 0; berr_a = 0;
    #1;
    chk("e_erro_pulse", 32'(erro_a), 1);
    chk("e_cyc", 32'(cyc_a), 0);
    chk("e_busy", 32'(busy_a), 0);
    @(negedge clk);
    chk("e_erro_clear", 32'(erro_a), 0);

    // Ack every other cycle: address/cti hold in the gaps
    req_a = 1; radr_a = 32'h1000_0014;
    @(negedge clk);
    req_a = 0;
    for (int i = 0; i < 8; i++) begin
      ack_a = 0; done_a = 0;
      #1;
      chk("ws_gap_adr", adr_a, exp32[i]);
      chk("ws_gap_cti", 32'(cti_a), (i == 7) ? 7 : 2);
      chk("ws_gap_we",  32'(we_a), 0);
      @(negedge clk);
      ack_a = 1; done_a = (i == 7);
      #1;
      chk("ws_adr", adr_a, exp32[i]);
      chk("ws_we",  32'(we_a), 1);
      @(negedge clk);
    end
    ack_a = 0; done_a = 0;
    #1 chk("ws_end_busy", 32'(busy_a), 0);

    // Reset after 3 acks, then a clean restart from a new address
    req_a = 1; radr_a = 32'h1000_0014;
    @(negedge clk);
    req_a = 0;
    for (int i = 0; i < 3; i++) begin
      ack_a = 1;
      @(negedge clk);
    end
    ack_a = 0; rst = 1;
    @(negedge clk);
    chk("mr_cyc",  32'(cyc_a), 0);
    chk("mr_stb",  32'(stb_a), 0);
    chk("mr_adr",  adr_a, 0);
    chk("mr_cti",  32'(cti_a), 0);
    chk("mr_bte",  32'(bte_a), 0);
    chk("mr_busy", 32'(busy_a), 0);
    chk("mr_err",  32'(erro_a), 0);
    chk("mr_we",   32'(we_a), 0);
    rst = 0;
    req_a = 1; radr_a = 32'h1000_0024;
    @(negedge clk);
    req_a = 0;
    for (int i = 0; i < 8; i++) begin
      ack_a = 1; done_a = (i == 7);
      #1;
      chk("rs_adr", adr_a, 32'h1000_0020 | 32'(((restart_off + i) % 8) * 4));
      chk("rs_cti", 32'(cti_a), (i == 7) ? 7 : 2);
      @(negedge clk);
    end
    ack_a = 0; done_a = 0;
    #1 chk("rs_end_busy", 32'(busy_a), 0);

    // 16 B line
    req_b = 1; radr_b = 32'h2000_0008;
    @(negedge clk);
    req_b = 0;
    chk("l16_cyc", 32'(cyc_b), 1);
    chk("l16_bte", 32'(bte_b), 1);
    for (int i = 0; i < 4; i++) begin
      ack_b = 1; dat_b = 32'hB000_0000 + 32'(i); done_b = (i == 3);
      #1;
      chk("l16_adr", adr_b, exp16[i]);
      chk("l16_cti", 32'(cti_b), (i == 3) ? 7 : 2);
      chk("l16_we",  32'(we_b), 1);
      @(negedge clk);
    end
    ack_b = 0; done_b = 0;
    #1;
    chk("l16_end_busy", 32'(busy_b), 0);
    chk("l16_end_cyc",  32'(cyc_b), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mor1kx_icache_refill_ctrl.md
# mor1kx_icache_refill_ctrl

Wishbone B3 burst master that services instruction-cache line refills. It sits between the instruction cache and the instruction bus. On a cache miss it fetches one full cache block as a wrapping burst. Each returned word is presented to the cache's write port (write address, write data, write enable), and bus errors are reported back to the cache.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, data and address width.
- OPTION_ICACHE_BLOCK_WIDTH, 5, log2 of block bytes; only 4 or 5 are legal (4 or 8 words).

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- refill_req_i  in  1  cache requests a refill (miss)
- refill_adr_i  in  32  miss address (the cache's match address)
- refill_done_i  in  1  cache reports that the next write completes the line
- wradr_o  out  32  cache write address
- wrdat_o  out  32  cache write data
- we_o  out  1  cache write strobe
- err_o  out  1  one-cycle bus-error pulse to the cache
- busy_o  out  1  burst in progress
- wbm_adr_o  out  32  bus address, word aligned
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle / strobe
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  burst type
- wbm_ack_i, wbm_err_i  in  1  bus ack / error
- wbm_dat_i  in  32  bus read data

## Operation
- States: IDLE, BURST.
- IDLE → BURST:
  - Taken when refill_req_i=1.
  - Latches the start address, and loads the beat counter with N-1, where N = 2^(BLOCK_WIDTH-2).
- BURST, bus signals:
  - cyc=stb=1.
  - bte = 2'b01 (wrap4) for 16 B blocks, 2'b10 (wrap8) for 32 B blocks.
  - cti = 3'b010 on every beat except the last, which uses 3'b111.
- BURST, address:
  - Advances on each ack.
  - The word offset [BW-1:2] increments modulo N; the upper bits are held constant.
- Write-port outputs:
  - we_o = wbm_ack_i & BURST & !wbm_err_i.
  - wradr_o = wbm_adr_o; wrdat_o = wbm_dat_i. All are combinational, so the write lands in the same cycle as the ack.
- Beat counter: decrements on each ack; the ack received at count 0 is the last beat.
- BURST → IDLE on the last ack:
  - cyc, stb, cti and bte are cleared at the next edge.
  - refill_done_i must coincide with this ack. If it does not, this is a protocol error; an assertion flags it in simulation.
- wbm_err_i in BURST:
  - No write occurs that cycle.
  - err_o=1 for exactly one cycle, registered, on the next cycle.
  - State returns to IDLE and cyc drops.
  - A simultaneous ack is ignored: error has priority.
- ack or err received in IDLE is ignored.
- busy_o = (state==BURST).

## Timing
- Reset values:
  - state IDLE.
  - wbm_cyc_o=0, wbm_stb_o=0, wbm_cti_o=0, wbm_bte_o=0, wbm_adr_o=0.
  - err_o=0, we_o=0, busy_o=0.
- Request latency: refill_req_i sampled at edge T gives cyc/stb=1 from T+1.
- Bus wait states: the address, cti and counter hold while ack=0; the controller has no timeout.
- Throughput: one word per acked cycle. An 8-word line with zero wait states occupies 8 BURST cycles.
- Back-to-back refills: at least one IDLE cycle between bursts. A request held high during the final ack is re-evaluated only in IDLE.
- Reset mid-burst: cyc/stb drop at the next edge, no err_o, the counter is discarded.

## Configuration
- MOR1KX_ICACHE_CRITICAL_WORD_FIRST_EN
  - Defined: the burst starts at refill_adr_i[31:2] (the missed word first) and wraps through the block.
  - Undefined: the burst starts at the block-aligned address, with refill_adr_i[BW-1:0] forced to 0.
  - bte and the beat count are the same in both modes.

## Structure
- Package mor1kx_icache_pkg holds:
  - State encodings (IDLE, BURST).
  - Wishbone constants: CTI_CLASSIC=3'b000, CTI_INC=3'b010, CTI_EOB=3'b111, BTE_WRAP4=2'b01, BTE_WRAP8=2'b10.
- Natural sub-module: mor1kx_wrap_adr_gen. It takes a base address, the block width and an advance strobe, and produces the wrapped address plus a last-beat flag.

## Test plan
- Critical-word-first, 32 B, request 0x1000_0014, zero wait states:
  - Addresses 14,18,1C,00,04,08,0C,10.
  - cti 010×7 then 111; bte 10.
  - 8 we_o pulses; busy_o low the cycle after the 8th ack.
- Macro undefined, same request → addresses 0x1000_0000..0x1000_001C in order.
- 16 B block, request 0x2000_0008 → addresses 08,0C,00,04; bte 01; 4 beats.
- wbm_err_i on the 3rd beat with ack also high:
  - Exactly 2 writes.
  - err_o high for 1 cycle.
  - cyc low next edge; state IDLE.
- ack every other cycle → adr/cti hold during the gaps; 8 writes total; no duplicate addresses.
- rst asserted after 3 acks → all outputs at reset values next edge; a new request then restarts cleanly from the new address.
